// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Optional phase-align input sync_i is built only when PHASE_SYNC_EN is defined.
module freq_div_multi #(
    parameter int          CH          = 4,
    parameter int          CNT_W       = 26,
    parameter int unsigned DIV_DEFAULT = 50_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       ch_en,
    input  logic [CH-1:0]       mode,
    input  logic [CH-1:0]       cfg_wr,
    input  logic [CH*CNT_W-1:0] div_cfg,
`ifdef PHASE_SYNC_EN
    input  logic                sync_i,
`endif
    output logic [CH-1:0]       clk_out,
    output logic [CH-1:0]       tick,
    output logic [CH-1:0]       cfg_err
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DDEF = CNT_W'(DIV_DEFAULT);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt, div, pend;
        logic [CNT_W-1:0] wdata, cnt_nxt, half;
        logic             pend_vld, wrap, wr_ok, wr_bad;
        logic             clk_r, tick_r, err_r;
        logic             sync;

`ifdef PHASE_SYNC_EN
        assign sync = sync_i;
`else
        assign sync = 1'b0;
`endif

        // Wrap detect, next count and the low-phase length ceil(div/2)
        always_comb begin
            wdata   = div_cfg[i*CNT_W +: CNT_W];
            wr_ok   = cfg_wr[i] && (wdata >= TWO);
            wr_bad  = cfg_wr[i] && (wdata < TWO);
            wrap    = (cnt == div - ONE);
            cnt_nxt = wrap ? '0 : cnt + ONE;
            half    = (div >> 1) + {{(CNT_W-1){1'b0}}, div[0]};
        end

        // Counter, divisor staging and registered outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                div      <= DDEF;
                pend     <= '0;
                pend_vld <= 1'b0;
                clk_r    <= 1'b0;
                tick_r   <= 1'b0;
                err_r    <= 1'b0;
            end else begin
                if (wr_bad)
                    err_r <= 1'b1;
                if (ch_en[i] && sync) begin
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    clk_r  <= 1'b0;
                    if (pend_vld) begin
                        div      <= pend;
                        pend_vld <= 1'b0;
                    end
                end else if (ch_en[i]) begin
                    cnt    <= cnt_nxt;
                    tick_r <= wrap;
                    clk_r  <= mode[i] ? wrap : (cnt_nxt >= half);
                    if (wrap && pend_vld) begin
                        div      <= pend;
                        pend_vld <= 1'b0;
                    end
                end else begin
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    clk_r  <= 1'b0;
                    if (pend_vld) begin
                        div      <= pend;
                        pend_vld <= 1'b0;
                    end
                end
                // A write captured this edge is applied no earlier than the next one
                if (wr_ok) begin
                    pend     <= wdata;
                    pend_vld <= 1'b1;
                end
            end
        end

        assign clk_out[i] = clk_r;
        assign tick[i]    = tick_r;
        assign cfg_err[i] = err_r;
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed self-checking bench for freq_div_multi.
// Phase-sync steps are included when PHASE_SYNC_EN is defined.
module tb_freq_div_multi;

    localparam int CH    = 4;
    localparam int CNT_W = 26;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       ch_en;
    logic [CH-1:0]       mode;
    logic [CH-1:0]       cfg_wr;
    logic [CH*CNT_W-1:0] div_cfg;
    logic                sync_i;
    logic [CH-1:0]       clk_out;
    logic [CH-1:0]       tick;
    logic [CH-1:0]       cfg_err;

    int checks = 0;
    int passes = 0;

    freq_div_multi #(.CH(CH), .CNT_W(CNT_W), .DIV_DEFAULT(50_000)) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .mode    (mode),
        .cfg_wr  (cfg_wr),
        .div_cfg (div_cfg),
`ifdef PHASE_SYNC_EN
        .sync_i  (sync_i),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int ch, input int val);
        div_cfg[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    initial begin
        int e, t0, r0, t1, n, m;
        logic [15:0] cp, tp, tq, cq;

        rst = 1'b1; ch_en = '0; mode = '0; cfg_wr = '0;
        div_cfg = '0; sync_i = 1'b0;
        repeat (3) step();
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);

        // Tests 1-3 share one default-length period on ch0/ch1
        rst = 1'b0; ch_en = 4'b0011;
        e = 0;
        repeat (10) begin step(); e++; end
        set_div(0, 5); cfg_wr = 4'b0001; step(); e++;
        set_div(1, 0); cfg_wr = 4'b0010; step(); e++;
        set_div(1, 1); step(); e++;
        cfg_wr = '0;
        chk("cfg_err_illegal", 32'(cfg_err), 32'h2);

        t0 = 0; r0 = 0; t1 = 0;
        while (e < 50000) begin
            step(); e++;
            if (tick[0] && t0 == 0) t0 = e;
            if (clk_out[0] && r0 == 0) r0 = e;
            if (tick[1] && t1 == 0) t1 = e;
        end
        chk("ch0_first_tick", 32'(t0), 32'd50000);
        chk("ch0_first_rise", 32'(r0), 32'd25000);
        chk("ch1_first_tick", 32'(t1), 32'd50000);
        chk("ch0_low_at_wrap", 32'(clk_out[0]), 32'h0);
        chk("cfg_err_sticky", 32'(cfg_err), 32'h2);

        cp = '0; tp = '0;
        for (int i = 0; i < 10; i++) begin
            step(); cp[i] = clk_out[0]; tp[i] = tick[0];
        end
        chk("ch0_div5_clk", 32'(cp), 32'h18C);
        chk("ch0_div5_tick", 32'(tp), 32'h210);

        ch_en = 4'b0001; set_div(1, 4); cfg_wr = 4'b0010; step();
        cfg_wr = '0; step();
        ch_en = 4'b0011;
        cp = '0; tp = '0;
        for (int i = 0; i < 8; i++) begin
            step(); cp[i] = clk_out[1]; tp[i] = tick[1];
        end
        chk("ch1_div4_clk", 32'(cp), 32'h66);
        chk("ch1_div4_tick", 32'(tp), 32'h88);
        chk("cfg_err_kept", 32'(cfg_err), 32'h2);

        // Test 4: ch2 pulse div 4, ch3 square div 6
        set_div(2, 4); set_div(3, 6); cfg_wr = 4'b1100; mode = 4'b0100; step();
        cfg_wr = '0; step();
        ch_en = 4'b1111;
        cp = '0; tp = '0; tq = '0; m = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            tq[i] = tick[2]; cp[i] = clk_out[3]; tp[i] = tick[3];
            if (clk_out[2] !== tick[2]) m++;
        end
        chk("ch2_pulse_tick", 32'(tq), 32'h888);
        chk("ch2_clk_eq_tick", 32'(m), 32'h0);
        chk("ch3_div6_clk", 32'(cp), 32'h71C);
        chk("ch3_div6_tick", 32'(tp), 32'h820);

        repeat (3) step();
        chk("ch3_high_phase", 32'(clk_out[3]), 32'h1);
        ch_en = 4'b0111; step();
        cq = {14'h0, clk_out[3], tick[3]};
        chk("ch3_disabled", 32'(cq), 32'h0);
        ch_en = 4'b1111;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (tick[3] && n == 0) n = i;
        end
        chk("ch3_reenable_tick", 32'(n), 32'd6);

        // Test 5: async reset between edges discards a pending write
        set_div(0, 7); cfg_wr = 4'b0001; step();
        cfg_wr = '0; step();
        #2 rst = 1'b1;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'h0);
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_cfg_err", 32'(cfg_err), 32'h0);
        step();
        rst = 1'b0; ch_en = 4'b0001; mode = '0;
        n = 0; m = 0;
        repeat (100) begin
            step();
            if (tick[0]) n++;
            if (clk_out[0]) m++;
        end
        chk("post_rst_no_tick", 32'(n), 32'h0);
        chk("post_rst_low", 32'(m), 32'h0);

`ifdef PHASE_SYNC_EN
        // Test 6: sync aligns ch0 (div 6) and ch1 (div 3)
        ch_en = '0; mode = 4'b0011;
        set_div(0, 6); set_div(1, 3); cfg_wr = 4'b0011; step();
        cfg_wr = '0; step();
        ch_en = 4'b0001; repeat (2) step();
        ch_en = 4'b0011; step();
        sync_i = 1'b1; step();
        sync_i = 1'b0;
        chk("sync_tick_clear", 32'(tick), 32'h0);
        tp = '0; tq = '0;
        for (int i = 0; i < 12; i++) begin
            step(); tp[i] = tick[0]; tq[i] = tick[1];
        end
        chk("sync_ch0_tick", 32'(tp), 32'h820);
        chk("sync_ch1_tick", 32'(tq), 32'h924);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
